nibble_up_stack: RTL
====================

Name: nibble_up_stack

Overview:
- Parametrised successor to the two-phase accumulator microprocessor.
- Fetch/execute phases, accumulator with C/Z flags, pushbutton input and output latch as before.
- Generalised in data width and address width; adds a hardware call/return stack, a HALT state and stack-error detection.
- Program ROM and data RAM are external and read combinationally. This block is the CPU core used on the board top level.

Parameters:
- DATA_W, 4, accumulator, operand, I/O and RAM data width.
- ADDR_W, 12, PC and RAM address width; legal range is ADDR_W <= 2*DATA_W+4.
- STACK_DEPTH, 4, number of return-address entries (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- prog_word  in  4+DATA_W  ROM word at pc; [top 4]=opcode, [DATA_W-1:0]=operand.
- pushbuttons  in  DATA_W  IN source.
- ram_rdata  in  DATA_W  RAM read data at ram_addr (combinational).
- pc  out  ADDR_W  program counter.
- ram_addr  out  ADDR_W  {operand, prog_word} truncated to ADDR_W; valid in execute.
- ram_wdata  out  DATA_W  equals accu.
- ram_we  out  1  write strobe; high only in the execute cycle of ST.
- instr  out  4  latched opcode.
- operand  out  DATA_W  latched operand.
- accu  out  DATA_W  accumulator.
- ff_out  out  DATA_W  output latch.
- c_flag  out  1  carry/no-borrow flag.
- z_flag  out  1  zero flag.
- phase  out  1  0=fetch, 1=execute.
- halted  out  1  core is in HALT.
- stack_err  out  1  sticky flag: stack overflow or underflow occurred.

Behaviour:
- Reset values (while reset=0): all outputs 0; state=FETCH; stack pointer 0.
- State machine: FETCH -> EXECUTE -> FETCH. HLT or a stack error -> HALT. HALT exits only by reset.
- FETCH cycle: instr/operand <= prog_word; pc <= pc+1. pc wraps modulo 2^ADDR_W.
- EXECUTE, single-word ops (pc unchanged unless stated):
  - LIT: A=imm.
  - IN: A=pushbuttons.
  - OUT: ff_out=A.
  - ADDI: {C,A}=A+imm; Z=(new A==0).
  - NORI: A=~(A|imm); Z updated; C unchanged.
  - CMPI: C=(A>=imm), Z=(A==imm); A unchanged.
  - RET: pc<=pop.
  - HLT: enter HALT.
  - LIT/IN/OUT leave flags untouched.
- EXECUTE, two-word ops: prog_word is the second word; target = ({operand, prog_word})[ADDR_W-1:0].
  - JMP: always taken.
  - JC/JNC/JZ/JNZ: taken on C / !C / Z / !Z.
  - Taken: pc<=target. Not taken: pc<=pc+1.
  - CALL: push pc+1; pc<=target.
  - LD: A<=ram_rdata at target; pc<=pc+1.
  - ST: ram_we=1, write A at target; pc<=pc+1.
- Cycle counts: single-word instruction = 2 cycles; two-word instruction = 2 cycles; no stalls.
- Stack boundaries:
  - CALL with sp==STACK_DEPTH: no push, pc unchanged, stack_err=1, enter HALT.
  - RET with sp==0: same response.
  - A push to the last free entry is legal.
- HALT: phase stays 0; ram_we=0; all registers frozen.
- Reset mid-instruction: aborts immediately, no partial write. ram_we is driven low asynchronously with reset.

Decomposition:
- Package nibble_up_pkg:
  - opcode enum: JC=0, JNC=1, JZ=2, JNZ=3, JMP=4, CALL=5, RET=6, LIT=7, IN=8, OUT=9, ADDI=A, NORI=B, CMPI=C, LD=D, ST=E, HLT=F.
  - state enum {FETCH, EXECUTE, HALT}.
  - helper function is_two_word(opcode).
- One sub-module, nibble_ret_stack:
  - parameters ADDR_W and STACK_DEPTH.
  - ports: push, pop, din, dout, full, empty.
  - LIFO, asynchronous active-low reset.
- ALU stays inline in the core.

Test Plan:
- Reset, then LIT 9 -> accu=1001 after cycle 2; phase toggles 0,1,0; pc=1.
- pushbuttons=0110; IN, OUT -> accu=0110, then ff_out=0110, flags unchanged.
- Add overflow:
  - LIT 9, ADDI 6 -> accu=1111, C=0, Z=0.
  - Then ADDI 1 -> accu=0000, C=1, Z=1.
- Compare and branch: CMPI 0 with A=0 gives Z=1 -> JZ 0x020 loads pc=0x020; JNZ not taken -> pc advances by 1.
- Stack overflow: CALL nested 4 times (STACK_DEPTH=4), then RET x4 -> returns to each pc+1 in LIFO order. A fifth nested CALL -> stack_err=1, halted=1, pc frozen.
- Memory and HLT:
  - ST 0x0A5 with A=0011 -> ram_we pulses one cycle at addr 0x0A5.
  - LD 0x0A5 -> A=0011.
  - HLT -> halted=1; reset clears it.

Source files
------------

// File: rtl/nibble_up_pkg.sv
// Shared opcode and state encodings for the nibble_up_stack CPU core.
package nibble_up_pkg;

    typedef enum logic [3:0] {
        OP_JC   = 4'h0,
        OP_JNC  = 4'h1,
        OP_JZ   = 4'h2,
        OP_JNZ  = 4'h3,
        OP_JMP  = 4'h4,
        OP_CALL = 4'h5,
        OP_RET  = 4'h6,
        OP_LIT  = 4'h7,
        OP_IN   = 4'h8,
        OP_OUT  = 4'h9,
        OP_ADDI = 4'hA,
        OP_NORI = 4'hB,
        OP_CMPI = 4'hC,
        OP_LD   = 4'hD,
        OP_ST   = 4'hE,
        OP_HLT  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXECUTE = 2'd1,
        ST_HALT    = 2'd2
    } state_e;

    // Ops whose execute cycle consumes the following ROM word as an address.
    function automatic logic is_two_word(input opcode_e op);
        return (op == OP_JC) || (op == OP_JNC) || (op == OP_JZ) || (op == OP_JNZ) ||
               (op == OP_JMP) || (op == OP_CALL) || (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/nibble_up_stack_ret_stack.sv
// Return-address LIFO for CALL/RET; top of stack is readable combinationally.
module nibble_ret_stack #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   top;

    assign full  = (sp_q == SP_W'(STACK_DEPTH));
    assign empty = (sp_q == '0);
    assign top   = sp_q - SP_W'(1);
    assign dout  = empty ? '0 : mem_q[top[IDX_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !full) begin
            mem_q[sp_q[IDX_W-1:0]] <= din;
            sp_q                   <= sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

endmodule

// File: rtl/nibble_up_stack.sv
// Two-phase accumulator CPU core with call/return stack, HALT state and
// sticky stack-error detection. ROM and RAM are external, read combinationally.
module nibble_up_stack
    import nibble_up_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W+3:0]   prog_word,
    input  logic [DATA_W-1:0]   pushbuttons,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic                ram_we,
    output logic [3:0]          instr,
    output logic [DATA_W-1:0]   operand,
    output logic [DATA_W-1:0]   accu,
    output logic [DATA_W-1:0]   ff_out,
    output logic                c_flag,
    output logic                z_flag,
    output logic                phase,
    output logic                halted,
    output logic                stack_err
);
    state_e              state_q;
    opcode_e             instr_q;
    logic [DATA_W-1:0]   operand_q, accu_q, ff_q;
    logic [ADDR_W-1:0]   pc_q;
    logic                c_q, z_q, err_q;

    logic [2*DATA_W+3:0] wide_target;
    logic [ADDR_W-1:0]   target, pc_inc, stk_dout;
    logic [DATA_W:0]     add_sum;
    logic [DATA_W-1:0]   nor_val;
    logic                taken, in_exec;
    logic                stk_push, stk_pop, stk_full, stk_empty;

    // Second word supplies the low address bits; the latched operand extends it.
    assign wide_target = {operand_q, prog_word};
    assign target      = wide_target[ADDR_W-1:0];
    assign pc_inc      = pc_q + ADDR_W'(1);
    assign add_sum     = {1'b0, accu_q} + {1'b0, operand_q};
    assign nor_val     = ~(accu_q | operand_q);
    assign in_exec     = (state_q == ST_EXECUTE);

    always_comb begin
        taken = 1'b0;
        case (instr_q)
            OP_JC:   taken = c_q;
            OP_JNC:  taken = !c_q;
            OP_JZ:   taken = z_q;
            OP_JNZ:  taken = !z_q;
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign stk_push = in_exec && (instr_q == OP_CALL) && !stk_full;
    assign stk_pop  = in_exec && (instr_q == OP_RET) && !stk_empty;

    nibble_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            instr_q   <= OP_JC;
            operand_q <= '0;
            accu_q    <= '0;
            ff_q      <= '0;
            pc_q      <= '0;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    instr_q   <= opcode_e'(prog_word[DATA_W+3:DATA_W]);
                    operand_q <= prog_word[DATA_W-1:0];
                    pc_q      <= pc_inc;
                    state_q   <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    state_q <= ST_FETCH;
                    case (instr_q)
                        OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP:
                            pc_q <= taken ? target : pc_inc;
                        OP_CALL: begin
                            if (stk_full) begin
                                err_q   <= 1'b1;
                                state_q <= ST_HALT;
                            end else begin
                                pc_q <= target;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty) begin
                                err_q   <= 1'b1;
                                state_q <= ST_HALT;
                            end else begin
                                pc_q <= stk_dout;
                            end
                        end
                        OP_LIT:  accu_q <= operand_q;
                        OP_IN:   accu_q <= pushbuttons;
                        OP_OUT:  ff_q   <= accu_q;
                        OP_ADDI: begin
                            {c_q, accu_q} <= add_sum;
                            z_q           <= (add_sum[DATA_W-1:0] == '0);
                        end
                        OP_NORI: begin
                            accu_q <= nor_val;
                            z_q    <= (nor_val == '0);
                        end
                        OP_CMPI: begin
                            c_q <= (accu_q >= operand_q);
                            z_q <= (accu_q == operand_q);
                        end
                        OP_LD: begin
                            accu_q <= ram_rdata;
                            pc_q   <= pc_inc;
                        end
                        OP_ST:   pc_q    <= pc_inc;
                        OP_HLT:  state_q <= ST_HALT;
                        default: state_q <= ST_FETCH;
                    endcase
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Write strobe decodes from state, so the async reset clears it at once.
    assign ram_we    = in_exec && (instr_q == OP_ST);
    assign ram_addr  = (in_exec && is_two_word(instr_q)) ? target : '0;
    assign ram_wdata = accu_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign operand   = operand_q;
    assign accu      = accu_q;
    assign ff_out    = ff_q;
    assign c_flag    = c_q;
    assign z_flag    = z_q;
    assign phase     = in_exec;
    assign halted    = (state_q == ST_HALT);
    assign stack_err = err_q;

endmodule
